pi_channel_scheduler: RTL and testbench
=======================================

Name: pi_channel_scheduler

Overview:
- Time-multiplexes one PI datapath across NCH control loops: one Q8.24 multiplier and one saturating integrator update path.
- Requesters each present an error sample `epi` with a req/ack handshake.
- Round-robin arbitration picks one channel per update. The block sequences the Ki and Kp products, applies the anti-windup clamp, and writes back per-channel integrator state.
- Sits between the per-channel error/estimator stages and the actuator drive.

Parameters:
- NCH, 4, number of control channels (2..16).
- KI, 32'sh0000140A, integral gain, Q8.24.
- KP, 32'sh0084A233, proportional gain, Q8.24.
- VMIN, 32'shF6000000, lower output/integrator clamp (-10.0).
- VMAX, 32'sh0A000000, upper output/integrator clamp (+10.0).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NCH  per-channel update request; held until matching ack.
- epi  in  NCH*32  per-channel signed Q8.24 error; channel c is bits [32c+31:32c]; stable while req[c] high.
- clr  in  NCH  per-channel synchronous integrator clear.
- ack  out  NCH  one-cycle grant pulse; epi[c] has been captured.
- vc_out  out  32  signed Q8.24 control output of the last completed update.
- vc_ch  out  $clog2(NCH)  channel index of vc_out.
- vc_valid  out  1  one-cycle pulse; vc_out/vc_ch are new.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n low, async):
  - ack=0, vc_out=0, vc_ch=0, vc_valid=0, busy=0.
  - All vint[c]=0, round-robin pointer=0, state=IDLE.
  - Reset mid-update abandons the update with no writeback.
- Multiply rule: full 64-bit signed product, arithmetic shift right 24, keep low 32 bits (truncation, no rounding).
- FSM, one update every 4 cycles:
  - IDLE: if any req, grant the first requesting channel at or after ptr (circular). Latch its index and epi, pulse ack[g], set ptr=g+1 mod NCH, go to MUL_I. Otherwise stay in IDLE.
  - MUL_I: i_r = KI*epi_l. Go to MUL_P.
  - MUL_P: p_r = KP*epi_l. The single multiplier instance is muxed between KI and KP by state. Go to UPD.
  - UPD: compute s = vint[g] + i_r (33-bit) and v = s + p_r (34-bit). No 32-bit wrap is allowed.
    - If v >= VMAX: vc_out=VMAX and vint[g]=VMAX.
    - Else if v <= VMIN: vc_out=VMIN and vint[g]=VMIN.
    - Else: vc_out=v[31:0] and vint[g]=s clamped to [VMIN,VMAX].
    - In all cases vc_ch=g and vc_valid=1 for one cycle. Go to IDLE.
- Latency: req sampled at edge k gives ack high after edge k and vc_valid high after edge k+3. Back-to-back grants occur every 4 edges.
- Handshake:
  - A requester drops req in the cycle after ack.
  - req still high in the cycle ack is visible is ignored, because the FSM is not in IDLE.
  - req held past that point is treated as a new request.
  - epi changes after ack have no effect on the in-flight update.
- Clear:
  - clr[c] at an edge sets vint[c]=0.
  - If it coincides with the UPD writeback for c, clr wins: vint[c]=0, while vc_out still reports the computed value.
  - clr never blocks arbitration.
- vc_out and vc_ch hold their values between updates.

Decomposition:
- Shared package pi_pkg:
  - Q-format constants QW=32 and QFRAC=24.
  - Default KI/KP/VMIN/VMAX.
  - State enum {IDLE, MUL_I, MUL_P, UPD}.
- Sub-modules:
  - Reuse the existing qmult for the single shared multiplier.
  - One new sub-module, rr_arbiter, takes NCH-bit req and the pointer and returns grant index and valid, combinationally.

Test Plan:
- Single channel, ch0 epi=0x01000000 (1.0) from reset: ack[0] one cycle, vc_valid 3 cycles later, vc_out=0x0084B63D, vc_ch=0. A second update with the same epi gives vc_out=0x0084CA47.
- Positive saturation, epi=0x7F000000: vc_out=0x0A000000, vint=0x0A000000. A following epi=0 update gives vc_out=0x0A000000.
- Negative saturation, epi=0x81000000: vc_out=0xF6000000. epi=0 afterwards gives 0xF6000000. clr on that channel then epi=0 gives 0x00000000.
- Round robin, NCH=4, req=4'b1011 asserted together and each dropped after its ack: grants in order 0,1,3 at 4-edge spacing, vc_ch 0,1,3. Then with ptr=0, req=4'b1001 re-asserted grants 0 then 3.
- Independence: ch1 driven twice with 1.0 while ch2 gets one update with 1.0. ch2 vc_out=0x0084B63D, unaffected by ch1 history.
- Reset mid-update: rst_n low during MUL_P for ch2 gives no vc_valid and all outputs 0. A post-reset ch2 update with epi=1.0 gives 0x0084B63D.

Source files
------------

// File: rtl/pi_pkg.sv
// Shared Q-format constants, default loop gains/clamps and the scheduler state encoding.
package pi_pkg;

    localparam int QW    = 32;
    localparam int QFRAC = 24;

    localparam logic signed [QW-1:0] KI_DEF   = 32'sh0000140A;
    localparam logic signed [QW-1:0] KP_DEF   = 32'sh0084A233;
    localparam logic signed [QW-1:0] VMIN_DEF = 32'shF6000000;
    localparam logic signed [QW-1:0] VMAX_DEF = 32'sh0A000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_I = 2'd1,
        MUL_P = 2'd2,
        UPD   = 2'd3
    } pi_state_e;

endpackage

// File: rtl/qmult.sv
// Signed Q8.24 multiplier: full-width product, arithmetic shift by QFRAC, truncated to QW bits.
module qmult
    import pi_pkg::*;
(
    input  logic signed [QW-1:0] a,
    input  logic signed [QW-1:0] b,
    output logic signed [QW-1:0] y
);

    logic signed [2*QW-1:0] prod;

    assign prod = a * b;
    assign y    = QW'(prod >>> QFRAC);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting channel at or after ptr, circularly.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    output logic [CW-1:0]  grant,
    output logic           valid
);

    logic [CW:0]   sum;
    logic [CW-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            sum = {1'b0, ptr} + (CW+1)'(i);
            if (sum >= (CW+1)'(NCH)) begin
                sum = sum - (CW+1)'(NCH);
            end
            idx = sum[CW-1:0];
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/pi_channel_scheduler.sv
// Time-multiplexed PI controller: one shared Q8.24 multiplier and one saturating
// integrator update path serving NCH channels in round-robin order.
module pi_channel_scheduler
    import pi_pkg::*;
#(
    parameter int                   NCH  = 4,
    parameter logic signed [QW-1:0] KI   = KI_DEF,
    parameter logic signed [QW-1:0] KP   = KP_DEF,
    parameter logic signed [QW-1:0] VMIN = VMIN_DEF,
    parameter logic signed [QW-1:0] VMAX = VMAX_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NCH-1:0]             req,
    input  logic [NCH*QW-1:0]          epi,
    input  logic [NCH-1:0]             clr,
    output logic [NCH-1:0]             ack,
    output logic signed [QW-1:0]       vc_out,
    output logic [$clog2(NCH)-1:0]     vc_ch,
    output logic                       vc_valid,
    output logic                       busy
);

    localparam int CW = $clog2(NCH);
    localparam logic signed [QW+1:0] VMAX_X = (QW+2)'(VMAX);
    localparam logic signed [QW+1:0] VMIN_X = (QW+2)'(VMIN);

    pi_state_e state_q, state_d;

    logic [CW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        g_q, g_d;
    logic [CW-1:0]        vc_ch_q, vc_ch_d;
    logic [NCH-1:0]       ack_q, ack_d;
    logic                 vc_valid_q, vc_valid_d;
    logic signed [QW-1:0] epi_l_q, epi_l_d;
    logic signed [QW-1:0] i_r_q, i_r_d;
    logic signed [QW-1:0] p_r_q, p_r_d;
    logic signed [QW-1:0] vc_out_q, vc_out_d;
    logic signed [QW-1:0] vint_q [NCH];
    logic signed [QW-1:0] vint_d [NCH];

    logic [CW-1:0]        arb_grant;
    logic                 arb_valid;
    logic signed [QW-1:0] epi_sel;
    logic signed [QW-1:0] coeff;
    logic signed [QW-1:0] mult_y;
    logic signed [QW-1:0] vint_g;
    logic signed [QW+1:0] sum_s;
    logic signed [QW+1:0] sum_v;
    logic signed [QW-1:0] out_new;
    logic signed [QW-1:0] vint_new;

    rr_arbiter #(
        .NCH (NCH),
        .CW  (CW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // The single multiplier sees KP only in MUL_P; every other state feeds it KI.
    assign coeff = (state_q == MUL_P) ? KP : KI;

    qmult u_mult (
        .a (coeff),
        .b (epi_l_q),
        .y (mult_y)
    );

    always_comb begin
        epi_sel = '0;
        vint_g  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (CW'(c) == arb_grant) begin
                epi_sel = epi[c*QW +: QW];
            end
            if (CW'(c) == g_q) begin
                vint_g = vint_q[c];
            end
        end
    end

    // Wide sums so the clamp decisions see the true value rather than a 32-bit wrap.
    always_comb begin
        sum_s    = (QW+2)'(vint_g) + (QW+2)'(i_r_q);
        sum_v    = sum_s + (QW+2)'(p_r_q);
        out_new  = sum_v[QW-1:0];
        vint_new = sum_s[QW-1:0];
        if (sum_v >= VMAX_X) begin
            out_new  = VMAX;
            vint_new = VMAX;
        end else if (sum_v <= VMIN_X) begin
            out_new  = VMIN;
            vint_new = VMIN;
        end else if (sum_s >= VMAX_X) begin
            vint_new = VMAX;
        end else if (sum_s <= VMIN_X) begin
            vint_new = VMIN;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        g_d        = g_q;
        epi_l_d    = epi_l_q;
        i_r_d      = i_r_q;
        p_r_d      = p_r_q;
        ack_d      = '0;
        vc_valid_d = 1'b0;
        vc_out_d   = vc_out_q;
        vc_ch_d    = vc_ch_q;
        for (int c = 0; c < NCH; c++) begin
            vint_d[c] = vint_q[c];
        end

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    g_d     = arb_grant;
                    epi_l_d = epi_sel;
                    ack_d   = NCH'(1) << arb_grant;
                    ptr_d   = (arb_grant == CW'(NCH-1)) ? '0 : arb_grant + 1'b1;
                    state_d = MUL_I;
                end
            end
            MUL_I: begin
                i_r_d   = mult_y;
                state_d = MUL_P;
            end
            MUL_P: begin
                p_r_d   = mult_y;
                state_d = UPD;
            end
            UPD: begin
                vc_out_d   = out_new;
                vc_ch_d    = g_q;
                vc_valid_d = 1'b1;
                for (int c = 0; c < NCH; c++) begin
                    if (CW'(c) == g_q) begin
                        vint_d[c] = vint_new;
                    end
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A clear lands after the writeback so it wins for the integrator only.
        for (int c = 0; c < NCH; c++) begin
            if (clr[c]) begin
                vint_d[c] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            g_q        <= '0;
            epi_l_q    <= '0;
            i_r_q      <= '0;
            p_r_q      <= '0;
            ack_q      <= '0;
            vc_valid_q <= 1'b0;
            vc_out_q   <= '0;
            vc_ch_q    <= '0;
            for (int c = 0; c < NCH; c++) begin
                vint_q[c] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            g_q        <= g_d;
            epi_l_q    <= epi_l_d;
            i_r_q      <= i_r_d;
            p_r_q      <= p_r_d;
            ack_q      <= ack_d;
            vc_valid_q <= vc_valid_d;
            vc_out_q   <= vc_out_d;
            vc_ch_q    <= vc_ch_d;
            for (int c = 0; c < NCH; c++) begin
                vint_q[c] <= vint_d[c];
            end
        end
    end

    assign ack      = ack_q;
    assign vc_out   = vc_out_q;
    assign vc_ch    = vc_ch_q;
    assign vc_valid = vc_valid_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_pi_channel_scheduler.sv
// Self-checking bench for pi_channel_scheduler: directed literal cases plus randomized
// traffic compared every cycle against a transaction-level model of the scheduler.
module tb_pi_channel_scheduler;

   localparam logic signed [31:0] KI   = 32'sh0000140A;
   localparam logic signed [31:0] KP   = 32'sh0084A233;
   localparam logic signed [31:0] VMIN = 32'shF6000000;
   localparam logic signed [31:0] VMAX = 32'sh0A000000;
   localparam longint VMAXL = 167772160;
   localparam longint VMINL = -167772160;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [3:0]  clr;
   logic [31:0] epiArr [4];
   logic [127:0] epi;
   logic [3:0]  ack;
   logic [31:0] vcOut;
   logic [1:0]  vcCh;
   logic        vcValid;
   logic        busy;

   int nTests = 0;
   int nFail  = 0;

   assign epi = {epiArr[3], epiArr[2], epiArr[1], epiArr[0]};

   pi_channel_scheduler #(.NCH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .epi      (epi),
      .clr      (clr),
      .ack      (ack),
      .vc_out   (vcOut),
      .vc_ch    (vcCh),
      .vc_valid (vcValid),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Reference model state: integrators, rotation pointer and the one outstanding update.
   logic signed [31:0] mVint [4] = '{default: 32'sd0};
   logic [1:0]         mPtr = 2'd0;
   int                 mEdge = 0;
   int                 mNextFree = 0;
   bit                 mPend = 1'b0;
   logic [1:0]         mPendCh = 2'd0;
   logic signed [31:0] mPendEpi = 32'sd0;
   int                 mDue = 0;
   logic [3:0]         expAck = 4'd0;
   logic               expValid = 1'b0;
   logic [31:0]        expVcOut = 32'd0;
   logic [1:0]         expVcCh = 2'd0;
   logic               expBusy = 1'b0;
   logic [1:0]         mIdx;
   bit                 mFound;

   function automatic logic signed [31:0] qmul(input logic signed [31:0] k, input logic signed [31:0] e);
      longint p;
      p = (longint'(k) * longint'(e)) >>> 24;
      return p[31:0];
   endfunction

   // Each update is computed from the integrator value at writeback time, then clears apply.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 4; c++) mVint[c] = 32'sd0;
         mPtr = 2'd0; mEdge = 0; mNextFree = 0; mPend = 1'b0;
         expAck = 4'd0; expValid = 1'b0; expVcOut = 32'd0; expVcCh = 2'd0; expBusy = 1'b0;
      end else begin
         longint i, p, s, v;
         mEdge++;
         expAck = 4'd0;
         expValid = 1'b0;
         if (mPend && mEdge == mDue) begin
            i = qmul(KI, mPendEpi);
            p = qmul(KP, mPendEpi);
            s = longint'(mVint[mPendCh]) + i;
            v = s + p;
            if (v >= VMAXL) begin
               expVcOut = VMAX; mVint[mPendCh] = VMAX;
            end else if (v <= VMINL) begin
               expVcOut = VMIN; mVint[mPendCh] = VMIN;
            end else begin
               expVcOut = v[31:0];
               mVint[mPendCh] = (s >= VMAXL) ? VMAX : (s <= VMINL) ? VMIN : s[31:0];
            end
            expVcCh = mPendCh;
            expValid = 1'b1;
            mPend = 1'b0;
         end
         for (int c = 0; c < 4; c++) if (clr[c]) mVint[c] = 32'sd0;
         if (!mPend && mEdge >= mNextFree && req != 4'd0) begin
            mFound = 1'b0;
            for (int k = 0; k < 4; k++) begin
               mIdx = mPtr + 2'(k);
               if (!mFound && req[mIdx]) begin
                  mFound = 1'b1;
                  mPendCh = mIdx;
               end
            end
            mPendEpi = epiArr[mPendCh];
            mPend = 1'b1;
            mDue = mEdge + 3;
            mNextFree = mEdge + 4;
            expAck = 4'd1 << mPendCh;
            mPtr = mPendCh + 2'd1;
         end
         expBusy = mPend;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      checkOutput("ack", 32'(ack), 32'(expAck));
      checkOutput("vc_valid", 32'(vcValid), 32'(expValid));
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("vc_out", vcOut, expVcOut);
      checkOutput("vc_ch", 32'(vcCh), 32'(expVcCh));
   end

   task automatic timeoutFail(input string name);
      nTests++;
      nFail++;
      $display("[TB] FAIL %s: timeout waiting for DUT", name);
   endtask

   // Single handshake on one channel; returns result, channel and ack-to-valid latency.
   task automatic applyStimulus(input logic [1:0] ch, input logic [31:0] e,
                                output logic [31:0] out, output int och, output int lat);
      int n;
      bit got;
      out = 32'd0; och = -1; lat = -1;
      @(negedge clk);
      epiArr[ch] = e;
      req[ch] = 1'b1;
      got = 1'b0;
      for (n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (ack[ch]) got = 1'b1;
      end
      req[ch] = 1'b0;
      if (!got) begin
         timeoutFail("ack_wait");
         return;
      end
      got = 1'b0;
      for (n = 1; n <= 20 && !got; n++) begin
         @(negedge clk);
         if (vcValid) begin
            got = 1'b1;
            lat = n;
         end
      end
      if (!got) begin
         timeoutFail("valid_wait");
         return;
      end
      out = vcOut;
      och = int'(vcCh);
   endtask

   task automatic doReset();
      @(negedge clk);
      #1 rst_n = 1'b0;
      req = 4'd0;
      clr = 4'd0;
      @(negedge clk);
      checkOutput("rst_vc_out", vcOut, 32'd0);
      checkOutput("rst_vc_valid", 32'(vcValid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_ack", 32'(ack), 32'd0);
      @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   int gq[$];
   int cq[$];
   int tq[$];

   function automatic int at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic rrRun(input logic [3:0] mask);
      int cyc;
      int nWant;
      gq.delete(); cq.delete(); tq.delete();
      nWant = $countones(mask);
      @(negedge clk);
      for (int c = 0; c < 4; c++) epiArr[c] = 32'h01000000;
      req = mask;
      cyc = 0;
      while (cq.size() < nWant && cyc < 60) begin
         @(negedge clk);
         cyc++;
         for (int c = 0; c < 4; c++) begin
            if (ack[c]) begin
               gq.push_back(c);
               tq.push_back(cyc);
               req[c] = 1'b0;
            end
         end
         if (vcValid) cq.push_back(int'(vcCh));
      end
      req = 4'd0;
      if (cq.size() < nWant) timeoutFail("rr_wait");
   endtask

   function automatic logic [31:0] randEpi();
      if ($urandom_range(0, 3) == 0) return $urandom;
      return 32'($urandom_range(0, 32'h04000000)) - 32'h02000000;
   endfunction

   logic [31:0] res;
   int resCh;
   int lat;
   bit sawValid;

   initial begin
      rst_n = 1'b0;
      req = 4'd0;
      clr = 4'd0;
      for (int c = 0; c < 4; c++) epiArr[c] = 32'd0;
      doReset();

      // Single channel from reset, then a second identical update.
      applyStimulus(2'd0, 32'h01000000, res, resCh, lat);
      checkOutput("single_vc_out", res, 32'h0084B63D);
      checkOutput("single_vc_ch", 32'(resCh), 32'd0);
      checkOutput("single_latency", 32'(lat), 32'd3);
      applyStimulus(2'd0, 32'h01000000, res, resCh, lat);
      checkOutput("second_vc_out", res, 32'h0084CA47);

      // Saturation in both directions, then clear.
      applyStimulus(2'd1, 32'h7F000000, res, resCh, lat);
      checkOutput("pos_sat", res, 32'h0A000000);
      applyStimulus(2'd1, 32'h00000000, res, resCh, lat);
      checkOutput("pos_hold", res, 32'h0A000000);
      applyStimulus(2'd2, 32'h81000000, res, resCh, lat);
      checkOutput("neg_sat", res, 32'hF6000000);
      applyStimulus(2'd2, 32'h00000000, res, resCh, lat);
      checkOutput("neg_hold", res, 32'hF6000000);
      @(negedge clk); clr = 4'b0100;
      @(negedge clk); clr = 4'b0000;
      applyStimulus(2'd2, 32'h00000000, res, resCh, lat);
      checkOutput("clr_zero", res, 32'h00000000);

      // Round robin from pointer 0.
      doReset();
      rrRun(4'b1011);
      checkOutput("rr1_count", 32'(gq.size()), 32'd3);
      checkOutput("rr1_g0", 32'(at(gq, 0)), 32'd0);
      checkOutput("rr1_g1", 32'(at(gq, 1)), 32'd1);
      checkOutput("rr1_g2", 32'(at(gq, 2)), 32'd3);
      checkOutput("rr1_sp1", 32'(at(tq, 1) - at(tq, 0)), 32'd4);
      checkOutput("rr1_sp2", 32'(at(tq, 2) - at(tq, 1)), 32'd4);
      checkOutput("rr1_ch0", 32'(at(cq, 0)), 32'd0);
      checkOutput("rr1_ch1", 32'(at(cq, 1)), 32'd1);
      checkOutput("rr1_ch2", 32'(at(cq, 2)), 32'd3);
      rrRun(4'b1001);
      checkOutput("rr2_g0", 32'(at(gq, 0)), 32'd0);
      checkOutput("rr2_g1", 32'(at(gq, 1)), 32'd3);

      // Channel independence.
      doReset();
      applyStimulus(2'd1, 32'h01000000, res, resCh, lat);
      applyStimulus(2'd1, 32'h01000000, res, resCh, lat);
      checkOutput("ind_ch1", res, 32'h0084CA47);
      applyStimulus(2'd2, 32'h01000000, res, resCh, lat);
      checkOutput("ind_ch2", res, 32'h0084B63D);
      checkOutput("ind_ch2_idx", 32'(resCh), 32'd2);

      // Reset in the middle of an update abandons it.
      @(negedge clk);
      epiArr[2] = 32'h01000000;
      req[2] = 1'b1;
      sawValid = 1'b0;
      for (int n = 0; n < 20 && !sawValid; n++) begin
         @(negedge clk);
         if (ack[2]) sawValid = 1'b1;
      end
      req[2] = 1'b0;
      if (!sawValid) timeoutFail("mid_ack");
      @(negedge clk);
      checkOutput("mid_busy", 32'(busy), 32'd1);
      #1 rst_n = 1'b0;
      sawValid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (vcValid) sawValid = 1'b1;
      end
      checkOutput("mid_no_valid", 32'(sawValid), 32'd0);
      checkOutput("mid_vc_out", vcOut, 32'd0);
      checkOutput("mid_vc_ch", 32'(vcCh), 32'd0);
      checkOutput("mid_busy_rst", 32'(busy), 32'd0);
      #1 rst_n = 1'b1;
      applyStimulus(2'd2, 32'h01000000, res, resCh, lat);
      checkOutput("post_rst_ch2", res, 32'h0084B63D);

      // Randomized multi-channel traffic with sporadic clears.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         for (int c = 0; c < 4; c++) begin
            if (req[c] && ack[c]) begin
               req[c] = 1'b0;
               epiArr[c] = randEpi();
            end else if (!req[c] && $urandom_range(0, 3) == 0) begin
               epiArr[c] = randEpi();
               req[c] = 1'b1;
            end
            clr[c] = ($urandom_range(0, 40) == 0);
         end
      end
      @(negedge clk);
      req = 4'd0;
      clr = 4'd0;
      repeat (10) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
